// File: rtl/code_counter_pkg.sv
// Shared helpers for the code counter slice: hex-to-7-segment decode,
// binary-to-Gray conversion and display constants.
package code_counter_pkg;

  localparam int MAX_WIDTH = 8;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_ZERO  = 7'b1000000;

  // Active-low segment patterns, bit order gfedcba.
  function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = SEG_BLANK;
    endcase
    return seg;
  endfunction

  // Callers zero-extend into MAX_WIDTH and truncate the result back.
  function automatic logic [MAX_WIDTH-1:0] bin_to_gray(input logic [MAX_WIDTH-1:0] b);
    return b ^ (b >> 1);
  endfunction

endpackage

// File: rtl/code_counter_scan_seg_scan.sv
// seg_scan: multiplexed 7-segment driver; walks the anodes every SCAN_DIV
// cycles and shows the matching hex nibble of the count (blank above it).
module seg_scan
  import code_counter_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WIDTH-1:0]      binary,
  output logic [6:0]            seg,
  output logic [NUM_DIGITS-1:0] an
);

  localparam int NIBBLES = (WIDTH + 3) / 4;
  localparam int SC_W    = $clog2(SCAN_DIV);
  localparam int IDX_W   = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

  logic [SC_W-1:0]       scan_cnt;
  logic                  scan_wrap;
  logic [IDX_W-1:0]      idx;
  logic [IDX_W-1:0]      idx_next;
  logic [4*NIBBLES-1:0]  padded;
  logic [3:0]            nib;
  logic                  nib_valid;
  logic [6:0]            seg_next;
  logic [NUM_DIGITS-1:0] an_next;

  assign scan_wrap = (scan_cnt == SC_W'(SCAN_DIV - 1));

  always_comb begin
    idx_next = idx;
    if (scan_wrap) begin
      idx_next = (idx == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx + IDX_W'(1);
    end
  end

  // Segment and anode data both come from idx_next so they land on the same edge.
  always_comb begin
    padded            = '0;
    padded[WIDTH-1:0] = binary;
    nib               = '0;
    nib_valid         = 1'b0;
    for (int i = 0; i < NIBBLES; i++) begin
      if (idx_next == IDX_W'(i)) begin
        nib       = padded[4*i +: 4];
        nib_valid = 1'b1;
      end
    end
    seg_next = nib_valid ? hex_to_seg(nib) : SEG_BLANK;
    an_next  = ~(NUM_DIGITS'(1) << idx_next);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt <= '0;
      idx      <= '0;
      an       <= ~NUM_DIGITS'(1);
      seg      <= SEG_ZERO;
    end else begin
      scan_cnt <= scan_wrap ? '0 : scan_cnt + SC_W'(1);
      idx      <= idx_next;
      an       <= an_next;
      seg      <= seg_next;
    end
  end

endmodule

// File: rtl/code_counter_scan.sv
// code_counter_scan: prescaled up/down counter with binary, Gray and one-hot
// outputs plus a hex 7-segment scan. Define COUNTER_SATURATE_EN to clamp instead of wrap.
module code_counter_scan
  import code_counter_pkg::*;
#(
  parameter int WIDTH      = 3,
  parameter int TICK_DIV   = 100000000,
  parameter int SCAN_DIV   = 100000,
  parameter int NUM_DIGITS = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic                   dir,
  input  logic                   load,
  input  logic [WIDTH-1:0]       load_val,
  output logic [WIDTH-1:0]       binary,
  output logic [WIDTH-1:0]       grey,
  output logic [(1<<WIDTH)-1:0]  onehot,
  output logic                   tick,
  output logic                   wrap,
  output logic [6:0]             T,
  output logic [NUM_DIGITS-1:0]  AN
);

  localparam int PS_W = $clog2(TICK_DIV);
  localparam int OH_W = 1 << WIDTH;
  localparam logic [WIDTH-1:0] MAX_VAL = '1;

  logic [PS_W-1:0]  presc;
  logic             presc_last;
  logic [WIDTH-1:0] bin_next;
  logic             wrap_next;
  logic [WIDTH-1:0] grey_next;
  logic [OH_W-1:0]  onehot_next;

  assign presc_last = (presc == PS_W'(TICK_DIV - 1));

  // Free-running prescaler; tick is the registered terminal-count flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      presc <= '0;
      tick  <= 1'b0;
    end else begin
      presc <= presc_last ? '0 : presc + PS_W'(1);
      tick  <= presc_last;
    end
  end

  // Load beats a coincident step; a step only happens on tick cycles with en.
  always_comb begin
    bin_next  = binary;
    wrap_next = 1'b0;
    if (load) begin
      bin_next = load_val;
    end else if (tick && en) begin
`ifdef COUNTER_SATURATE_EN
      if (dir) begin
        if (binary != MAX_VAL) bin_next = binary + WIDTH'(1);
      end else begin
        if (binary != '0) bin_next = binary - WIDTH'(1);
      end
`else
      if (dir) begin
        bin_next  = binary + WIDTH'(1);
        wrap_next = (binary == MAX_VAL);
      end else begin
        bin_next  = binary - WIDTH'(1);
        wrap_next = (binary == '0);
      end
`endif
    end
  end

  always_comb begin
    grey_next   = WIDTH'(bin_to_gray(MAX_WIDTH'(bin_next)));
    onehot_next = OH_W'(1) << bin_next;
  end

  // All encodings derive from bin_next so they never disagree.
  always_ff @(posedge clk) begin
    if (rst) begin
      binary <= '0;
      grey   <= '0;
      onehot <= OH_W'(1);
      wrap   <= 1'b0;
    end else begin
      binary <= bin_next;
      grey   <= grey_next;
      onehot <= onehot_next;
      wrap   <= wrap_next;
    end
  end

  seg_scan #(
    .WIDTH      (WIDTH),
    .SCAN_DIV   (SCAN_DIV),
    .NUM_DIGITS (NUM_DIGITS)
  ) u_seg_scan (
    .clk    (clk),
    .rst    (rst),
    .binary (binary),
    .seg    (T),
    .an     (AN)
  );

endmodule
